// File: rtl/bcd_countdown99.sv
// Two-digit BCD down-counter (99..00) with clamped parallel load, start/pause and a one-cycle DONE pulse.
// All outputs registered; a decrement lands TICK_DIV cycles after START or after the previous decrement; no backpressure.
module bcd_countdown99 #(
  parameter int TICK_DIV = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOAD,
  input  logic [3:0] LD_HIGH,
  input  logic [3:0] LD_LOW,
  input  logic       START,
  input  logic       PAUSE,
  output logic [3:0] CNT_HIGH,
  output logic [3:0] CNT_LOW,
  output logic       BUSY,
  output logic       DONE
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [PW-1:0] presc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      presc    <= '0;
      CNT_HIGH <= 4'd0;
      CNT_LOW  <= 4'd0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (LOAD) begin
        CNT_HIGH <= (LD_HIGH > 4'd9) ? 4'd9 : LD_HIGH;
        CNT_LOW  <= (LD_LOW  > 4'd9) ? 4'd9 : LD_LOW;
        state    <= IDLE;
        BUSY     <= 1'b0;
        presc    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (START) begin
              if (CNT_HIGH == 4'd0 && CNT_LOW == 4'd0) begin
                DONE <= 1'b1;
              end else begin
                state <= RUN;
                BUSY  <= 1'b1;
                presc <= '0;
              end
            end
          end
          RUN: begin
            if (!PAUSE) begin
              if (presc == TICK_LAST) begin
                presc <= '0;
                if (CNT_LOW == 4'd0) begin
                  CNT_LOW  <= 4'd9;
                  CNT_HIGH <= CNT_HIGH - 4'd1;
                end else begin
                  CNT_LOW <= CNT_LOW - 4'd1;
                end
                // 01 -> 00 is the terminal step; RUN never holds 00, so no wrap is possible
                if (CNT_HIGH == 4'd0 && CNT_LOW == 4'd1) begin
                  state <= IDLE;
                  BUSY  <= 1'b0;
                  DONE  <= 1'b1;
                end
              end else begin
                presc <= presc + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
